wb_irq_router: RTL and testbench

// - Wishbone-programmable interrupt router. It replaces hard-wired or1k_irq assignments in the SoC top.
// - Collects NUM_SRC peripheral interrupts (UART, timers, GPIO, ...) and latches them per source.
// - Each source has its own mode (level/edge), mask and route. The 32-bit OR1K PIC vector is driven from the routed, masked pending bits.
// - Sits as a WB B3 classic slave on the data bus, beside uart0/rom0.

---
 rtl/irq_router_pkg.sv | 27 ++
 rtl/irq_src_latch.sv | 84 ++++++++
 rtl/wb_irq_router.sv | 143 ++++++++++++++
 tb/tb_wb_irq_router.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_router_pkg.sv
// Shared definitions for the Wishbone interrupt router.
//   - Register byte offsets of the slave register map.
//   - irq_route_t : 5-bit index of an OR1K PIC line (0..31).
//   - irq_mode_e  : per-source trigger mode (level / rising edge).
//   - route_reset : reset value of ROUTE[i] = (base + i) mod 32.
package irq_router_pkg;

    localparam logic [7:0] REG_PENDING    = 8'h00;
    localparam logic [7:0] REG_MASK       = 8'h04;
    localparam logic [7:0] REG_EDGE       = 8'h08;
    localparam logic [7:0] REG_RAW        = 8'h0C;
    localparam logic [7:0] REG_ROUTE_BASE = 8'h10;

    typedef logic [4:0] irq_route_t;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_mode_e;

    function automatic irq_route_t route_reset(input int base, input int idx);
        int unsigned s;
        s = int'(unsigned'(base + idx)) % 32;
        return s[4:0];
    endfunction

endpackage

// File: rtl/irq_src_latch.sv
// Per-source interrupt capture: input sampling (optionally a 2-flop
// synchroniser), rising-edge detect and the pending flop.
// Build option: IRQ_ROUTER_SYNC_EN adds the 2-flop synchroniser ahead of
// the sampling register (two extra cycles of latency).
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   src_i           raw interrupt input, active-high
//   mode_i          IRQ_LEVEL: pending follows input; IRQ_EDGE: rise sets
//   w1c_i           clear request for the pending bit (edge mode only)
//   mode_chg_i      mode is being changed this cycle: clear pending
//   raw_o           sampled (or synchronised) input
//   pending_o       pending flag
module irq_src_latch
    import irq_router_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      src_i,
    input  irq_mode_e mode_i,
    input  logic      w1c_i,
    input  logic      mode_chg_i,
    output logic      raw_o,
    output logic      pending_o
);

    logic sample_q;
    logic prev_q;
    logic pending_q;
    logic pending_d;

`ifdef IRQ_ROUTER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            sync1_q  <= src_i;
            sync2_q  <= sync1_q;
            sample_q <= sync2_q;
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= src_i;
        end
    end
`endif

    // Edge history keeps running in both modes, so switching to edge mode
    // while the input is already high does not fabricate an edge.
    always_comb begin
        pending_d = pending_q;
        if (mode_chg_i) begin
            pending_d = 1'b0;
        end else if (mode_i == IRQ_LEVEL) begin
            pending_d = sample_q;
        end else if (sample_q && !prev_q) begin
            pending_d = 1'b1;       // a new edge beats a simultaneous clear
        end else if (w1c_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= sample_q;
            pending_q <= pending_d;
        end
    end

    assign raw_o     = sample_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/wb_irq_router.sv
// Wishbone B3 classic programmable interrupt router for the OR1K PIC.
// Build option: IRQ_ROUTER_SYNC_EN (see irq_src_latch) synchronises the
// interrupt inputs for sources outside the wb_clk_i domain.
// Ports:
//   wb_clk_i, wb_rst_ni   clock, asynchronous active-low reset
//   wb_adr_i..wb_stb_i    Wishbone slave inputs (byte address, bits [1:0] unused)
//   wb_dat_o, wb_ack_o    read data and single-cycle acknowledge
//   irq_src_i             raw peripheral interrupts, active-high
//   or1k_irq_o            registered PIC vector; lines 0 and 1 never driven
// Handshake: a request (cyc & stb) is acknowledged one cycle later with a
// single-cycle ack; ack low in the request cycle qualifies it, so a held
// request is served every second cycle. Writes land on the edge that
// raises ack; read data is registered and valid while ack is high.
module wb_irq_router
    import irq_router_pkg::*;
#(
    parameter int NUM_SRC   = 8,
    parameter int ADR_W     = 8,
    parameter int ROUTE_RST = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [ADR_W-1:0]   wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic [31:0]        or1k_irq_o
);

    logic               ack_q;
    logic [31:0]        dat_q, dat_d;
    logic [31:0]        irq_q, irq_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    irq_route_t         route_q [NUM_SRC];
    irq_route_t         route_d [NUM_SRC];

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] mode_chg;

    logic               access;
    logic               wr;
    logic [31:0]        off;
    logic               sel_route;
    int                 route_idx;

    assign access = wb_cyc_i && wb_stb_i && !ack_q;
    assign wr     = access && wb_we_i;

    // Address decode on the word-aligned byte offset.
    always_comb begin
        off       = 32'({wb_adr_i[ADR_W-1:2], 2'b00});
        route_idx = int'((off - 32'(REG_ROUTE_BASE)) >> 2);
        sel_route = (off >= 32'(REG_ROUTE_BASE)) && (route_idx < NUM_SRC);
    end

    always_comb begin
        dat_d = 32'h0;
        if (access && !wb_we_i) begin
            if (off == 32'(REG_PENDING)) dat_d = 32'(pending);
            else if (off == 32'(REG_MASK)) dat_d = 32'(mask_q);
            else if (off == 32'(REG_EDGE)) dat_d = 32'(edge_q);
            else if (off == 32'(REG_RAW)) dat_d = 32'(raw);
            else if (sel_route) dat_d = 32'(route_q[route_idx]);
        end
    end

    always_comb begin
        mask_d   = mask_q;
        edge_d   = edge_q;
        route_d  = route_q;
        w1c      = '0;
        mode_chg = '0;
        if (wr) begin
            if (off == 32'(REG_PENDING)) begin
                w1c = wb_dat_i[NUM_SRC-1:0];
            end else if (off == 32'(REG_MASK)) begin
                mask_d = wb_dat_i[NUM_SRC-1:0];
            end else if (off == 32'(REG_EDGE)) begin
                edge_d   = wb_dat_i[NUM_SRC-1:0];
                mode_chg = wb_dat_i[NUM_SRC-1:0] ^ edge_q;
            end else if (sel_route) begin
                route_d[route_idx] = wb_dat_i[4:0];
            end
        end
    end

    // Lines 0 and 1 are the non-maskable OR1K inputs and stay undriven.
    always_comb begin
        irq_d = 32'h0;
        for (int k = 2; k < 32; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (pending[i] && mask_q[i] && (route_q[i] == irq_route_t'(k))) begin
                    irq_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q  <= 1'b0;
            dat_q  <= 32'h0;
            irq_q  <= 32'h0;
            mask_q <= '0;
            edge_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                route_q[i] <= route_reset(ROUTE_RST, i);
            end
        end else begin
            ack_q   <= access;
            dat_q   <= dat_d;
            irq_q   <= irq_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            route_q <= route_d;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_src_latch u_latch (
            .clk_i      (wb_clk_i),
            .rst_ni     (wb_rst_ni),
            .src_i      (irq_src_i[g]),
            .mode_i     (irq_mode_e'(edge_q[g])),
            .w1c_i      (w1c[g]),
            .mode_chg_i (mode_chg[g]),
            .raw_o      (raw[g]),
            .pending_o  (pending[g])
        );
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign or1k_irq_o = irq_q;

endmodule

// File: tb/tb_wb_irq_router.sv
module tb_wb_irq_router;

    logic        clk;
    logic        rst_n;
    logic [7:0]  adr;
    logic [31:0] dat_w;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] dat_r;
    logic        ack;
    logic [7:0]  src;
    logic [31:0] irq;

    int total;
    int bad;

    wb_irq_router #(.NUM_SRC(8), .ADR_W(8), .ROUTE_RST(2)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_w),
        .wb_we_i    (we),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_dat_o   (dat_r),
        .wb_ack_o   (ack),
        .irq_src_i  (src),
        .or1k_irq_o (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: request at a negedge, ack expected at the next negedge
    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
        @(negedge clk);
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL wr_ack adr=%h got=%b want=1", a, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        @(negedge clk);
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL rd_ack adr=%h got=%b want=1", a, ack);
        end
        d = dat_r;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        @(negedge clk);
        total++;
        if (ack !== 1'b0 || dat_r !== 32'h0 || irq !== 32'h0) begin
            bad++;
            $display("FAIL reset_outs ack=%b dat=%h irq=%h want 0/0/0", ack, dat_r, irq);
        end
        rst_n = 1'b1;
        wb_read(8'h00, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_pending got=%h want=0", d); end
        wb_read(8'h04, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mask got=%h want=0", d); end
        wb_read(8'h08, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_edge got=%h want=0", d); end
        wb_read(8'h1C, d);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL rst_route3 got=%h want=5", d); end
        wb_read(8'h2C, d);
        total++; if (d !== 32'h9) begin bad++; $display("FAIL rst_route7 got=%h want=9", d); end
    endtask

    task automatic test_level();
        logic [31:0] d;
        wb_write(8'h04, 32'h01);
        wb_write(8'h10, 32'h02);
        src[0] = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (irq !== 32'h0) begin bad++; $display("FAIL lvl_early got=%h want=0", irq); end
        @(negedge clk);
        total++; if (irq !== 32'h4) begin bad++; $display("FAIL lvl_rise got=%h want=4", irq); end
        wb_read(8'h0C, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL lvl_raw got=%h want=1", d); end
        wb_write(8'h00, 32'h01);
        @(negedge clk);
        total++; if (irq !== 32'h4) begin bad++; $display("FAIL lvl_w1c_irq got=%h want=4", irq); end
        wb_read(8'h00, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL lvl_w1c_pend got=%h want=1", d); end
        src[0] = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (irq !== 32'h4) begin bad++; $display("FAIL lvl_fall_early got=%h want=4", irq); end
        @(negedge clk);
        total++; if (irq !== 32'h0) begin bad++; $display("FAIL lvl_fall got=%h want=0", irq); end
    endtask

    task automatic test_edge();
        logic [31:0] d;
        wb_write(8'h08, 32'h02);
        wb_write(8'h04, 32'h02);
        wb_write(8'h14, 32'h07);
        @(negedge clk); src[1] = 1'b1;
        @(negedge clk); src[1] = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (irq !== 32'h80) begin bad++; $display("FAIL edge_irq got=%h want=80", irq); end
        wb_read(8'h00, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL edge_pend got=%h want=2", d); end
        repeat (5) @(negedge clk);
        total++; if (irq !== 32'h80) begin bad++; $display("FAIL edge_hold got=%h want=80", irq); end
        wb_write(8'h00, 32'h02);
        repeat (2) @(negedge clk);
        total++; if (irq !== 32'h0) begin bad++; $display("FAIL edge_clr_irq got=%h want=0", irq); end
        wb_read(8'h00, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_clr_pend got=%h want=0", d); end
        // edge and clear land on the same clock edge
        @(negedge clk); src[1] = 1'b1;
        @(negedge clk); src[1] = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h00; dat_w = 32'h02;
        @(negedge clk);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL race_ack got=%b want=1", ack); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wb_read(8'h00, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL race_set_wins got=%h want=2", d); end
        wb_write(8'h00, 32'h02);
        wb_read(8'h00, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL race_clr got=%h want=0", d); end
    endtask

    task automatic test_mode_change();
        logic [31:0] d;
        src[3] = 1'b1;
        repeat (3) @(negedge clk);
        wb_read(8'h00, d);
        total++; if (d !== 32'h8) begin bad++; $display("FAIL mode_lvl_pend got=%h want=8", d); end
        wb_write(8'h08, 32'h0A);
        repeat (3) @(negedge clk);
        wb_read(8'h00, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mode_chg_clr got=%h want=0", d); end
        src[3] = 1'b0;
    endtask

    task automatic test_shared_line();
        logic [31:0] d;
        wb_write(8'h08, 32'h00);
        wb_write(8'h04, 32'h05);
        wb_write(8'h10, 32'h04);
        wb_write(8'h18, 32'h04);
        src[0] = 1'b1; src[2] = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (irq !== 32'h10) begin bad++; $display("FAIL share_both got=%h want=10", irq); end
        src[0] = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (irq !== 32'h10) begin bad++; $display("FAIL share_one got=%h want=10", irq); end
        wb_write(8'h10, 32'h01);
        src[0] = 1'b1; src[2] = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (irq !== 32'h0) begin bad++; $display("FAIL nmi_line got=%h want=0", irq); end
        wb_read(8'h00, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL nmi_pend got=%h want=1", d); end
        wb_write(8'h24, 32'hFFFF_FFE3);
        wb_read(8'h24, d);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL route_trunc got=%h want=3", d); end
        wb_write(8'h30, 32'h1F);
        wb_read(8'h30, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL route_oob got=%h want=0", d); end
        src[0] = 1'b0;
    endtask

    task automatic test_unmapped_and_reset();
        logic [31:0] d;
        wb_read(8'hFC, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped got=%h want=0", d); end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h04;
        @(posedge clk); #1;
        total++; if (ack !== 1'b1 || dat_r !== 32'h5) begin
            bad++; $display("FAIL mid_ack ack=%b dat=%h want 1/5", ack, dat_r);
        end
        rst_n = 1'b0;
        #1;
        total++; if (ack !== 1'b0 || dat_r !== 32'h0 || irq !== 32'h0) begin
            bad++; $display("FAIL mid_rst ack=%b dat=%h irq=%h want 0/0/0", ack, dat_r, irq);
        end
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        wb_read(8'h04, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL post_mask got=%h want=0", d); end
        wb_read(8'h08, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL post_edge got=%h want=0", d); end
        wb_read(8'h10, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL post_route0 got=%h want=2", d); end
        wb_read(8'h1C, d);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL post_route3 got=%h want=5", d); end
        wb_read(8'h00, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL post_pend got=%h want=0", d); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; adr = '0; dat_w = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; src = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_level();
        test_edge();
        test_mode_change();
        test_shared_line();
        test_unmapped_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // bound on the whole run
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
